// File: rtl/bl_zone_scheduler_if.sv
// LED-driver stream between the zone scheduler (master) and the LED driver (slave).
// Carries one zone level per beat with its index and an end-of-frame marker.
interface bl_zone_scheduler_if #(
  parameter int IDX_W = 9
);
  logic [7:0]       tx_data;
  logic [IDX_W-1:0] tx_idx;
  logic             tx_valid;
  logic             tx_last;
  logic             tx_ready;

  modport master (
    output tx_data,
    output tx_idx,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_idx,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/bl_zone_scheduler.sv
// Ping-pong backlight zone store: collects one frame of zone levels, then streams them to the
// LED driver on the next frame_sync edge. Optional floor clamp: define BL_MIN_CLAMP_EN.
module bl_zone_scheduler #(
  parameter int ZONES = 360,
  parameter int IDX_W = 9
) (
  input  logic                       i_pix_clk,
  input  logic                       rst,
  input  logic                       zone_vld,
  input  logic [IDX_W-1:0]           zone_idx,
  input  logic [7:0]                 zone_val,
  input  logic                       frame_sync,
  input  logic [1:0]                 gray_mode_req,
  input  logic [7:0]                 min_level,
  output logic [1:0]                 gray_mode,
  bl_zone_scheduler_if.master        tx,
  output logic                       busy,
  output logic                       ovr_err
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_FETCH = 2'd1;
  localparam logic [1:0]       ST_SEND  = 2'd2;
  localparam logic [1:0]       GRAY_RST = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ZONES - 1);

  logic [7:0]       bank0_q [0:ZONES-1];
  logic [7:0]       bank1_q [0:ZONES-1];
  logic [7:0]       rd_data_q;
  logic [7:0]       beat_data_s;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             primed_q, primed_d;
  logic             prev_q;
  logic [1:0]       gray_mode_q, gray_mode_d;
  logic             ovr_err_q, ovr_err_d;
  logic             busy_q;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_last_q, tx_last_d;

  logic             wr_en_s;
  logic             rd_en_s;
  logic             fs_edge_s;
  logic             swap_s;

  assign wr_en_s   = zone_vld & (zone_idx <= LAST_IDX);
  assign fs_edge_s = frame_sync & ~prev_q;
  assign swap_s    = fs_edge_s & primed_q & (state_q == ST_IDLE);

`ifdef BL_MIN_CLAMP_EN
  logic [7:0] floor_q, floor_d;

  function automatic logic [7:0] apply_floor(input logic [7:0] val, input logic [7:0] lvl);
    return (val < lvl) ? lvl : val;
  endfunction

  assign beat_data_s = apply_floor(rd_data_q, floor_q);

  // Floor level is frozen for the whole frame at the swap.
  always_comb begin
    floor_d = floor_q;
    if (swap_s) begin
      floor_d = min_level;
    end else begin
      floor_d = floor_q;
    end
  end

  // Floor register.
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      floor_q <= 8'd0;
    end else begin
      floor_q <= floor_d;
    end
  end
`else
  logic unused_min_s;
  assign unused_min_s = ^min_level;
  assign beat_data_s  = rd_data_q;
`endif

  // Bank storage is deliberately not reset; primed keeps stale contents off the stream.
  always_ff @(posedge i_pix_clk) begin
    if (wr_en_s) begin
      if (wr_bank_q) begin
        bank1_q[zone_idx] <= zone_val;
      end else begin
        bank0_q[zone_idx] <= zone_val;
      end
    end
    if (rd_en_s) begin
      rd_data_q <= wr_bank_q ? bank0_q[ptr_q] : bank1_q[ptr_q];
    end
  end

  // Sequencer next state: bank swap, per-zone fetch and the stream handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_bank_d   = wr_bank_q;
    primed_d    = primed_q | wr_en_s;
    gray_mode_d = gray_mode_q;
    ovr_err_d   = ovr_err_q;
    tx_data_d   = tx_data_q;
    tx_idx_d    = tx_idx_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    rd_en_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fs_edge_s) begin
          gray_mode_d = gray_mode_req;
          if (primed_q) begin
            // A write landing on this cycle went to the bank now being read out.
            wr_bank_d = ~wr_bank_q;
            primed_d  = 1'b0;
            ptr_d     = '0;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_en_s = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = beat_data_s;
          tx_idx_d   = ptr_q;
          tx_last_d  = (ptr_q == LAST_IDX);
        end else if (tx.tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        ptr_d      = '0;
        state_d    = ST_IDLE;
      end
    endcase

    if (fs_edge_s && (state_q != ST_IDLE)) begin
      ovr_err_d = 1'b1;
    end else begin
      ovr_err_d = ovr_err_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      wr_bank_q   <= 1'b0;
      primed_q    <= 1'b0;
      prev_q      <= 1'b0;
      gray_mode_q <= GRAY_RST;
      ovr_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_idx_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_bank_q   <= wr_bank_d;
      primed_q    <= primed_d;
      prev_q      <= frame_sync;
      gray_mode_q <= gray_mode_d;
      ovr_err_q   <= ovr_err_d;
      busy_q      <= (state_d != ST_IDLE);
      tx_data_q   <= tx_data_d;
      tx_idx_q    <= tx_idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
    end
  end

  assign gray_mode   = gray_mode_q;
  assign ovr_err     = ovr_err_q;
  assign busy        = busy_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_idx   = tx_idx_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_last  = tx_last_q;

endmodule

// File: tb/tb_bl_zone_scheduler.sv
// Directed bench for bl_zone_scheduler: reset, priming, full frames with back-pressure,
// overrun, swap-cycle write routing, ignored indices and mid-stream reset.
module tb_bl_zone_scheduler;
  localparam int ZONES = 360;
  localparam int IDX_W = 9;

  logic             clk;
  logic             rst;
  logic             zone_vld;
  logic [IDX_W-1:0] zone_idx;
  logic [7:0]       zone_val;
  logic             frame_sync;
  logic [1:0]       gray_mode_req;
  logic [7:0]       min_level;
  logic [1:0]       gray_mode;
  logic             busy;
  logic             ovr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [0:ZONES-1];

  bl_zone_scheduler_if #(.IDX_W(IDX_W)) tx_if ();

  bl_zone_scheduler #(.ZONES(ZONES), .IDX_W(IDX_W)) dut (
    .i_pix_clk     (clk),
    .rst           (rst),
    .zone_vld      (zone_vld),
    .zone_idx      (zone_idx),
    .zone_val      (zone_val),
    .frame_sync    (frame_sync),
    .gray_mode_req (gray_mode_req),
    .min_level     (min_level),
    .gray_mode     (gray_mode),
    .tx            (tx_if),
    .busy          (busy),
    .ovr_err       (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_zone(input int idx, input logic [7:0] val);
    zone_vld = 1'b1;
    zone_idx = IDX_W'(idx);
    zone_val = val;
    tick();
    zone_vld = 1'b0;
  endtask

  // Raise frame_sync for one sampled edge, optionally with a zone write in the same cycle.
  task automatic fire_edge(input bit with_wr, input int idx, input logic [7:0] val);
    frame_sync = 1'b1;
    if (with_wr) begin
      zone_vld = 1'b1;
      zone_idx = IDX_W'(idx);
      zone_val = val;
    end
    tick();
    frame_sync = 1'b0;
    zone_vld   = 1'b0;
  endtask

  task automatic expect_no_stream(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | tx_if.tx_valid | busy;
      tick();
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  // Receive one full frame against exp_q; inject adds the mid-frame edge and writes.
  task automatic recv_stream(input int pct_low, input bit inject);
    int beats;
    int cyc;
    bit pend;
    bit rdy;
    bit ev0, ev1, ev2;
    logic [7:0]       pd;
    logic [IDX_W-1:0] pi;
    logic             pl;
    beats = 0; cyc = 0; pend = 1'b0;
    ev0 = 1'b0; ev1 = 1'b0; ev2 = 1'b0;
    pd = 8'd0; pi = '0; pl = 1'b0;
    while (beats < ZONES && cyc < 6000) begin
      if (pend) begin
        check_val("hold_valid", 32'(tx_if.tx_valid), 32'd1);
        check_val("hold_data", 32'(tx_if.tx_data), 32'(pd));
        check_val("hold_idx", 32'(tx_if.tx_idx), 32'(pi));
        check_val("hold_last", 32'(tx_if.tx_last), 32'(pl));
      end
      rdy = ($urandom_range(0, 99) >= pct_low);
      tx_if.tx_ready = rdy;
      if (inject) begin
        if (beats >= 100 && !ev0) begin
          frame_sync = 1'b1; gray_mode_req = 2'b00;
          zone_vld = 1'b1; zone_idx = IDX_W'(7); zone_val = 8'h33;
          ev0 = 1'b1;
        end else if (ev0 && !ev1) begin
          zone_vld = 1'b1; zone_idx = IDX_W'(7); zone_val = 8'h44;
          ev1 = 1'b1;
        end else if (ev1 && !ev2) begin
          zone_vld = 1'b0; frame_sync = 1'b0;
          ev2 = 1'b1;
        end else begin
          zone_vld = 1'b0;
        end
      end
      if (tx_if.tx_valid && rdy) begin
        check_val("beat_idx", 32'(tx_if.tx_idx), 32'(beats));
        check_val("beat_data", 32'(tx_if.tx_data), 32'(exp_q[beats]));
        check_val("beat_last", 32'(tx_if.tx_last), 32'(beats == ZONES - 1));
        beats++;
        pend = 1'b0;
      end else if (tx_if.tx_valid) begin
        pend = 1'b1;
        pd = tx_if.tx_data; pi = tx_if.tx_idx; pl = tx_if.tx_last;
      end else begin
        pend = 1'b0;
      end
      tick();
      cyc++;
    end
    tx_if.tx_ready = 1'b0;
    check_val("beat_count", 32'(beats), 32'(ZONES));
    check_val("busy_after", 32'(busy), 32'd0);
    check_val("valid_after", 32'(tx_if.tx_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; zone_vld = 1'b0; zone_idx = '0; zone_val = 8'd0;
    frame_sync = 1'b0; gray_mode_req = 2'b00; min_level = 8'd0; tx_if.tx_ready = 1'b0;
    tick(); tick();
    check_val("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    check_val("rst_last", 32'(tx_if.tx_last), 32'd0);
    check_val("rst_data", 32'(tx_if.tx_data), 32'd0);
    check_val("rst_idx", 32'(tx_if.tx_idx), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ovr", 32'(ovr_err), 32'd0);
    check_val("rst_gray", 32'(gray_mode), 32'd2);
    rst = 1'b0;
    tick();

    // Edge with nothing written: mode follows the request, no stream.
    gray_mode_req = 2'b01;
    fire_edge(1'b0, 0, 8'd0);
    expect_no_stream("unprimed_no_stream");
    check_val("unprimed_gray", 32'(gray_mode), 32'd1);

    // Frame 1: full ready, first-beat latency.
    for (int i = 0; i < ZONES; i++) begin
      wr_zone(i, i[7:0]);
      exp_q[i] = i[7:0];
    end
    gray_mode_req = 2'b11;
    fire_edge(1'b0, 0, 8'd0);
    check_val("lat_e0", 32'(tx_if.tx_valid), 32'd0);
    tick();
    check_val("lat_e1", 32'(tx_if.tx_valid), 32'd0);
    tick();
    check_val("lat_e2", 32'(tx_if.tx_valid), 32'd1);
    check_val("f1_busy", 32'(busy), 32'd1);
    check_val("f1_gray", 32'(gray_mode), 32'd3);
    recv_stream(0, 1'b0);
    check_val("f1_ovr", 32'(ovr_err), 32'd0);

    // Frame 2: 30% back-pressure, swap-cycle write to zone 5, overrun edge at beat 100.
    for (int i = 0; i < ZONES; i++) begin
      wr_zone(i, i[7:0] ^ 8'h5A);
      exp_q[i] = i[7:0] ^ 8'h5A;
    end
    exp_q[5] = 8'h77;
    fire_edge(1'b1, 5, 8'h77);
    recv_stream(30, 1'b1);
    check_val("f2_ovr", 32'(ovr_err), 32'd1);
    check_val("f2_gray", 32'(gray_mode), 32'd3);
    expect_no_stream("f2_no_restart");

    // Frame 3: bank written during frame 2 holds frame-1 data plus the newest zone 7 value.
    for (int i = 0; i < ZONES; i++) exp_q[i] = i[7:0];
    exp_q[7] = 8'h44;
    fire_edge(1'b0, 0, 8'd0);
    recv_stream(30, 1'b0);
    check_val("f3_ovr_sticky", 32'(ovr_err), 32'd1);

    // Out-of-range index is ignored and does not prime a stream.
    wr_zone(400, 8'hAA);
    gray_mode_req = 2'b01;
    fire_edge(1'b0, 0, 8'd0);
    expect_no_stream("idx400_no_stream");
    check_val("idx400_gray", 32'(gray_mode), 32'd1);

    // Floor clamp (or pass-through), then reset in the middle of the stream.
    wr_zone(0, 8'd10);
    wr_zone(1, 8'd200);
    min_level = 8'd40;
    fire_edge(1'b0, 0, 8'd0);
    min_level = 8'd0;
    for (int k = 0; k < 10 && !tx_if.tx_valid; k++) tick();
    check_val("floor_valid", 32'(tx_if.tx_valid), 32'd1);
`ifdef BL_MIN_CLAMP_EN
    check_val("floor_b0", 32'(tx_if.tx_data), 32'd40);
`else
    check_val("floor_b0", 32'(tx_if.tx_data), 32'd10);
`endif
    tx_if.tx_ready = 1'b1;
    tick();
    tx_if.tx_ready = 1'b0;
    for (int k = 0; k < 10 && !tx_if.tx_valid; k++) tick();
    check_val("floor_b1_idx", 32'(tx_if.tx_idx), 32'd1);
    check_val("floor_b1", 32'(tx_if.tx_data), 32'd200);
    rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(tx_if.tx_valid), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_ovr", 32'(ovr_err), 32'd0);
    check_val("arst_gray", 32'(gray_mode), 32'd2);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bl_zone_scheduler.md
BL_ZONE_SCHEDULER -- requirements
Module: bl_zone_scheduler

Interface
REQ-001 SHALL have parameter ZONES, 360, number of backlight zones per frame.
REQ-002 SHALL have parameter IDX_W, 9, width of zone index.
REQ-003 SHALL have port i_pix_clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port zone_vld  input  1  one-cycle pulse: zone result available (from zone statistics block flag_done).
REQ-006 SHALL have port zone_idx  input  IDX_W  zone number of current result (cnt_360).
REQ-007 SHALL have port zone_val  input  8  zone backlight level (buf_360_flatted).
REQ-008 SHALL have port frame_sync  input  1  vertical sync level (r_Vsync_0).
REQ-009 SHALL have port gray_mode_req  input  2  requested algorithm mode, software domain.
REQ-010 SHALL have port min_level  input  8  minimum backlight floor.
REQ-011 SHALL have port gray_mode  output  2  mode applied to statistics block, frame-aligned.
REQ-012 SHALL have ports tx_data (output 8), tx_idx (output IDX_W), tx_valid (output 1), tx_last (output 1), tx_ready (input 1): LED-driver stream.
REQ-013 SHALL have ports busy (output 1, stream in progress) and ovr_err (output 1, sticky overrun).

Function
REQ-014 SHALL hold two ZONES x 8 banks (ping-pong); one is write bank, the other read bank.
REQ-015 SHALL write zone_val at zone_idx into write bank on every zone_vld with zone_idx < ZONES; zone_idx >= ZONES ignored.
REQ-016 SHALL detect frame_sync rising edge with one registered previous sample; edge = frame_sync & ~prev.
REQ-017 SHALL, on edge in IDLE with primed=1: swap banks, latch gray_mode <= gray_mode_req, clear primed, enter FETCH.
REQ-018 SHALL set primed on any accepted write; edge with primed=0 only latches gray_mode, no stream.
REQ-019 SHALL, on edge in FETCH/SEND: no swap, gray_mode unchanged, set ovr_err; write bank keeps accumulating (newer values overwrite).
REQ-020 SHALL implement states IDLE, FETCH, SEND; FETCH issues read at read pointer (1-cycle read latency) then -> SEND.
REQ-021 SHALL in SEND assert tx_valid with tx_data, tx_idx = pointer; tx_data/tx_idx/tx_last stable while tx_valid & ~tx_ready.
REQ-022 SHALL on tx_valid & tx_ready: pointer = ZONES-1 -> IDLE, pointer cleared; else pointer+1 -> FETCH (max one beat per 2 cycles).
REQ-023 SHALL assert tx_last only with tx_idx = ZONES-1; busy = state != IDLE.
REQ-024 SHALL raise tx_valid first exactly 2 clock edges after the edge sampling the frame_sync rising edge.
REQ-025 SHALL route zone_vld coinciding with the swap cycle into the pre-swap write bank.
REQ-026 SHALL clear ovr_err only by reset.

Reset
REQ-027 SHALL on rst: state IDLE, tx_valid 0, tx_last 0, tx_data 0, tx_idx 0, busy 0, ovr_err 0, gray_mode 2'b10, primed 0, write bank 0, prev 0.
REQ-028 SHALL not clear bank storage on reset; primed gating prevents streaming stale data.
REQ-029 SHALL on rst mid-stream drop tx_valid asynchronously; partial frame is abandoned.

Configuration
REQ-030 SHALL, with BL_MIN_CLAMP_EN defined, output tx_data = max(bank value, min_level), min_level sampled at swap.
REQ-031 SHALL, without BL_MIN_CLAMP_EN, output bank value unmodified and ignore min_level.

Verification
REQ-032 SHALL cover: write zones 0..359 with val=idx[7:0], frame_sync edge, tx_ready=1 -> 360 beats, tx_idx 0..359, tx_data=idx[7:0], tx_last on 359, busy falls after.
REQ-033 SHALL cover: tx_ready toggled random 30% -> no data change while valid&~ready, no beat lost or duplicated.
REQ-034 SHALL cover: second frame_sync edge at beat 100 -> ovr_err=1, stream completes 360 beats, gray_mode unchanged.
REQ-035 SHALL cover: edge after reset with no writes -> no tx_valid; gray_mode_req=2'b01 -> gray_mode=2'b01.
REQ-036 SHALL cover: BL_MIN_CLAMP_EN, min_level=40, zone value 10 -> tx_data 40; value 200 -> 200.
REQ-037 SHALL cover: zone_vld idx=400 -> ignored; zone_vld at swap cycle, idx 5 val 0x77 -> 0x77 appears in next frame's stream.
